pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives PC write-enable, IF/ID write/flush
//  and ID/EX bubble insertion. Resolves load-use hazards, taken-branch flushes, I-mem wait states
//  and D-mem freezes. Sits beside the hazard-free datapath; its only state is a small FSM plus

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/sat_counter.sv | 36 +++
 rtl/pipeline_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } ctrl_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != C_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Stall/flush sequencer for the 5-stage pipeline (load-use, branch
//            redirect, I-mem wait, D-mem freeze) with performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_stall,
  output logic             pc_write,
  output logic             pc_sel_target,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_t r_state;
  ctrl_state_t w_state_next;
  logic        w_lu;
  logic        w_stall_inc;
  logic        w_flush_inc;

  assign w_lu = ex_mem_read && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    pc_write      = 1'b0;
    pc_sel_target = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    pipe_freeze   = 1'b0;

    if (reset) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (dmem_stall) begin
      // EX is held, so a pending branch is simply seen again after the freeze.
      pipe_freeze = 1'b1;
    end else if (ex_branch_taken) begin
      pc_write      = 1'b1;
      pc_sel_target = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      w_flush_inc   = 1'b1;
      w_state_next  = imem_ready ? ST_RUN : ST_REDIRECT;
    end else if (r_state == ST_REDIRECT) begin
      if (imem_ready) begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        w_state_next = ST_RUN;
      end else begin
        if_id_flush = 1'b1;
        w_stall_inc = 1'b1;
      end
    end else if (w_lu) begin
      id_ex_bubble = 1'b1;
      w_stall_inc  = 1'b1;
    end else if (!imem_ready) begin
      if_id_write = 1'b1;
      if_id_flush = 1'b1;
      w_stall_inc = 1'b1;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall_inc),
    .clear (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_flush_inc),
    .clear (1'b0),
    .count (flush_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Self-checking bench; directed scenarios plus random traffic
//            against a rule-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;
  localparam int C_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [REG_W-1:0] id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_mem_read, ex_branch_taken, imem_ready, dmem_stall;
  logic             pc_write, pc_sel_target, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .imem_ready      (imem_ready),
    .dmem_stall      (dmem_stall),
    .pc_write        (pc_write),
    .pc_sel_target   (pc_sel_target),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .pipe_freeze     (pipe_freeze),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  // Output vector order: {pc_write, pc_sel_target, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}
  wire [5:0] obs = {pc_write, pc_sel_target, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze};

  int       n_vec = 0;
  int       n_bad = 0;
  bit       m_redirect = 1'b0;   // waiting for I-mem after a taken branch
  int       m_stall = 0;
  int       m_flush = 0;
  logic [5:0] e_out, e_mask;

  function automatic bit lu_hit();
    return ex_mem_read && (ex_rt != 0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

  // Expected outputs for the current inputs; mask clears don't-care bits.
  task automatic model_eval();
    e_mask = 6'b111111;
    if (reset)                 e_out = 6'b000110;
    else if (dmem_stall)       e_out = 6'b000001;
    else if (ex_branch_taken) begin e_out = 6'b110110; e_mask = 6'b110111; end
    else if (m_redirect) begin
      if (imem_ready) begin e_out = 6'b101000; e_mask = 6'b111101; end
      else begin e_out = 6'b000100; e_mask = 6'b110101; end
    end
    else if (lu_hit())         e_out = 6'b000010;
    else if (!imem_ready)      e_out = 6'b001100;
    else                       e_out = 6'b101000;
  endtask

  task automatic model_update();
    if (reset) begin
      m_redirect = 1'b0; m_stall = 0; m_flush = 0;
    end else if (dmem_stall) begin
    end else if (ex_branch_taken) begin
      m_flush = (m_flush == C_MAX) ? C_MAX : m_flush + 1;
      m_redirect = !imem_ready;
    end else if (m_redirect) begin
      if (imem_ready) m_redirect = 1'b0;
      else m_stall = (m_stall == C_MAX) ? C_MAX : m_stall + 1;
    end else if (lu_hit() || !imem_ready) begin
      m_stall = (m_stall == C_MAX) ? C_MAX : m_stall + 1;
    end
  endtask

  task automatic set_in(input int rs, input int rt, input bit uses, input bit mr,
                        input int ert, input bit br, input bit im, input bit ds);
    id_rs = REG_W'(rs); id_rt = REG_W'(rt); id_uses_rt = uses; ex_mem_read = mr;
    ex_rt = REG_W'(ert); ex_branch_taken = br; imem_ready = im; dmem_stall = ds;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk); #1; model_eval();
    n_vec++;
    if ((obs & e_mask) !== (e_out & e_mask)) begin
      n_bad++; $display("FAIL reset_outputs got %b want %b", obs, e_out);
    end
    n_vec++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      n_bad++; $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    tick(); @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_load_use();
    for (int pass = 0; pass < 2; pass++) begin
      int reg_no = (pass == 0) ? 8 : 0;
      int base = m_stall;
      @(negedge clk); set_in(reg_no, 3, 0, 1, reg_no, 0, 1, 0); #1; model_eval();
      n_vec++;
      if ((obs & e_mask) !== (e_out & e_mask)) begin
        n_bad++; $display("FAIL load_use_r%0d got %b want %b", reg_no, obs, e_out);
      end
      tick();
      @(negedge clk); ex_mem_read = 1'b0; #1; model_eval();
      n_vec++;
      if ((obs & e_mask) !== (e_out & e_mask) || e_out !== 6'b101000) begin
        n_bad++; $display("FAIL load_use_after got %b want %b", obs, 6'b101000);
      end
      tick();
      n_vec++;
      if (stall_cnt !== CNT_W'(base + ((pass == 0) ? 1 : 0)) || stall_cnt !== CNT_W'(m_stall)) begin
        n_bad++; $display("FAIL load_use_cnt got %0d want %0d", stall_cnt, base + ((pass == 0) ? 1 : 0));
      end
    end
  endtask

  task automatic test_uses_rt();
    for (int u = 0; u < 2; u++) begin
      @(negedge clk); set_in(4, 9, u[0], 1, 9, 0, 1, 0); #1; model_eval();
      n_vec++;
      if ((obs & e_mask) !== (e_out & e_mask) || id_ex_bubble !== u[0]) begin
        n_bad++; $display("FAIL uses_rt_%0d got %b want %b", u, obs, e_out);
      end
      tick();
    end
  endtask

  task automatic test_branch_redirect();
    int s0 = m_stall;
    int f0 = m_flush;
    @(negedge clk); set_in(8, 0, 0, 1, 8, 1, 0, 0); #1; model_eval();
    n_vec++;
    if ((obs & e_mask) !== (e_out & e_mask)) begin
      n_bad++; $display("FAIL branch_redirect got %b want %b", obs, e_out);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); set_in(1, 2, 1, 0, 0, 0, 0, 0); #1; model_eval();
      n_vec++;
      if ((obs & e_mask) !== (e_out & e_mask)) begin
        n_bad++; $display("FAIL redirect_wait%0d got %b want %b", c, obs, e_out);
      end
      tick();
    end
    @(negedge clk); imem_ready = 1'b1; #1; model_eval();
    n_vec++;
    if ((obs & e_mask) !== (e_out & e_mask) || if_id_write !== 1'b1) begin
      n_bad++; $display("FAIL redirect_done got %b want %b", obs, e_out);
    end
    tick();
    n_vec++;
    if (flush_cnt !== CNT_W'(f0 + 1) || stall_cnt !== CNT_W'(s0 + 3)) begin
      n_bad++; $display("FAIL redirect_cnt got %0d/%0d want %0d/%0d", flush_cnt, stall_cnt, f0 + 1, s0 + 3);
    end
  endtask

  task automatic test_dmem_freeze();
    int s0 = m_stall;
    int f0 = m_flush;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); set_in(8, 0, 0, 1, 8, 1, 1, 1); #1; model_eval();
      n_vec++;
      if ((obs & e_mask) !== (e_out & e_mask)) begin
        n_bad++; $display("FAIL freeze%0d got %b want %b", c, obs, e_out);
      end
      tick();
    end
    n_vec++;
    if (stall_cnt !== CNT_W'(s0) || flush_cnt !== CNT_W'(f0)) begin
      n_bad++; $display("FAIL freeze_cnt got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, s0, f0);
    end
    @(negedge clk); dmem_stall = 1'b0; #1; model_eval();
    n_vec++;
    if ((obs & e_mask) !== (e_out & e_mask) || pc_sel_target !== 1'b1) begin
      n_bad++; $display("FAIL freeze_release got %b want %b", obs, e_out);
    end
    tick();
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
  endtask

  task automatic test_reset_mid_redirect();
    @(negedge clk); set_in(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    @(negedge clk); ex_branch_taken = 1'b0;
    tick();
    @(negedge clk); reset = 1'b1; model_update(); #1; model_eval();
    n_vec++;
    if ((obs & e_mask) !== (e_out & e_mask) || stall_cnt !== 0 || flush_cnt !== 0) begin
      n_bad++; $display("FAIL reset_mid_redirect got %b cnt %0d/%0d want %b cnt 0/0",
                        obs, stall_cnt, flush_cnt, e_out);
    end
    tick();
    @(negedge clk); reset = 1'b0; imem_ready = 1'b1; #1; model_eval();
    n_vec++;
    if ((obs & e_mask) !== (e_out & e_mask) || e_out !== 6'b101000) begin
      n_bad++; $display("FAIL after_reset_run got %b want %b", obs, 6'b101000);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
      reset = ($urandom_range(0, 99) == 0);
      if (reset) model_update();
      #1; model_eval();
      n_vec++;
      if ((obs & e_mask) !== (e_out & e_mask)) begin
        n_bad++; $display("FAIL random%0d outputs got %b want %b", c, obs, e_out);
      end
      tick();
      n_vec++;
      if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
        n_bad++; $display("FAIL random%0d counters got %0d/%0d want %0d/%0d",
                          c, stall_cnt, flush_cnt, m_stall, m_flush);
      end
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_saturation();
    @(negedge clk); reset = 1'b1; set_in(5, 0, 0, 1, 5, 0, 1, 0); model_update();
    tick();
    @(negedge clk); reset = 1'b0;
    repeat (C_MAX - 1) tick();
    n_vec++;
    if (stall_cnt !== 16'hFFFE || m_stall != 16'hFFFE) begin
      n_bad++; $display("FAIL sat_pre got %h want fffe", stall_cnt);
    end
    tick(); tick();
    n_vec++;
    if (stall_cnt !== 16'hFFFF || m_stall != C_MAX) begin
      n_bad++; $display("FAIL sat_hold got %h want ffff", stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_uses_rt();
    test_branch_redirect();
    test_dmem_freeze();
    test_reset_mid_redirect();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
